// File: rtl/gates_bist.sv
// Built-in self-test engine for the two-input gates block: walks the 2-bit truth table, checks all five responses.
// Optional build macro GATES_BIST_STOP_ON_FAIL_EN ends the run at the first failing vector.
module gates_bist #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned LOOPS         = 1,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             iClk,
    input  logic             iRstn,
    input  logic             iStart,
    output logic             oA,
    output logic             oB,
    input  logic             iAND,
    input  logic             iOR,
    input  logic             iNOT,
    input  logic             iNAND,
    input  logic             iNAND2,
    output logic             oBusy,
    output logic             oDone,
    output logic             oPass,
    output logic [4:0]       oFailMask,
    output logic [1:0]       oFailVec,
    output logic [CNT_W-1:0] oErrCnt
);

    localparam int unsigned SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;
    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [LOOP_W-1:0] LOOP_LAST = LOOP_W'(LOOPS - 1);
    localparam logic [CNT_W-1:0]  ERR_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t             state_q, state_nxt;
    logic [SET_W-1:0]   cnt_q, cnt_nxt;
    logic [1:0]         vec_q, vec_nxt;
    logic [LOOP_W-1:0]  loop_q, loop_nxt;
    logic               busy_q, busy_nxt;
    logic               done_q, done_nxt;
    logic               pass_q, pass_nxt;
    logic [4:0]         mask_q, mask_nxt;
    logic [1:0]         fvec_q, fvec_nxt;
    logic [CNT_W-1:0]   err_q, err_nxt;

    logic [4:0]         resp;
    logic [4:0]         expd;
    logic [4:0]         mism;
    logic               any_mism;
    logic               stop_now;
    logic               last_vec;

    // Expected gate responses for the vector currently applied
    always_comb begin
        resp = {iNAND2, iNAND, iNOT, iOR, iAND};
        expd = {~(vec_q[1] & vec_q[0]), ~(vec_q[1] & vec_q[0]), ~vec_q[1],
                vec_q[1] | vec_q[0], vec_q[1] & vec_q[0]};
        // Case inequality so an X/Z response registers as a mismatch in simulation
        for (int i = 0; i < 5; i++) begin
            mism[i] = (resp[i] !== expd[i]);
        end
        any_mism = |mism;
        last_vec = (vec_q == 2'b11) && (loop_q == LOOP_LAST);
`ifdef GATES_BIST_STOP_ON_FAIL_EN
        stop_now = any_mism;
`else
        stop_now = 1'b0;
`endif
    end

    always_ff @(posedge iClk) begin
        if (!iRstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            loop_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            mask_q  <= '0;
            fvec_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            vec_q   <= vec_nxt;
            loop_q  <= loop_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
            pass_q  <= pass_nxt;
            mask_q  <= mask_nxt;
            fvec_q  <= fvec_nxt;
            err_q   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        vec_nxt   = vec_q;
        loop_nxt  = loop_q;
        busy_nxt  = busy_q;
        done_nxt  = done_q;
        pass_nxt  = pass_q;
        mask_nxt  = mask_q;
        fvec_nxt  = fvec_q;
        err_nxt   = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (iStart) begin
                    state_nxt = S_SETTLE;
                    cnt_nxt   = '0;
                    vec_nxt   = 2'b00;
                    loop_nxt  = '0;
                    busy_nxt  = 1'b1;
                    done_nxt  = 1'b0;
                    pass_nxt  = 1'b0;
                    mask_nxt  = '0;
                    fvec_nxt  = '0;
                    err_nxt   = '0;
                end
            end
            S_SETTLE: begin
                cnt_nxt = cnt_q + SET_W'(1);
                if (cnt_q == SET_LAST) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (any_mism) begin
                    mask_nxt = mask_q | mism;
                    if (err_q == '0) begin
                        fvec_nxt = vec_q;
                    end
                    if (err_q != ERR_MAX) begin
                        err_nxt = err_q + CNT_W'(1);
                    end
                end
                if (last_vec || stop_now) begin
                    state_nxt = S_DONE;
                    vec_nxt   = 2'b00;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    pass_nxt  = (err_nxt == '0);
                end else begin
                    state_nxt = S_SETTLE;
                    vec_nxt   = vec_q + 2'd1;
                    cnt_nxt   = '0;
                    if (vec_q == 2'b11) begin
                        loop_nxt = loop_q + LOOP_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign oA        = vec_q[1];
    assign oB        = vec_q[0];
    assign oBusy     = busy_q;
    assign oDone     = done_q;
    assign oPass     = pass_q;
    assign oFailMask = mask_q;
    assign oFailVec  = fvec_q;
    assign oErrCnt   = err_q;

endmodule

// File: tb/tb_gates_bist.sv
// Directed bench for gates_bist: a behavioural gates model with fault injection feeds two BIST instances.
module tb_gates_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn, start1, start2;
    logic       f_not0, f_nand2_1;

    logic       a1, b1, busy1, done1, pass1;
    logic [4:0] mask1;
    logic [1:0] fv1;
    logic [7:0] err1;
    logic       a2, b2, busy2, done2, pass2;
    logic [4:0] mask2;
    logic [1:0] fv2;
    logic [7:0] err2;

    int checks = 0;
    int errors = 0;
    int edges;

    gates_bist #(.SETTLE_CYCLES(2), .LOOPS(1), .CNT_W(8)) u_dut1 (
        .iClk(clk), .iRstn(rstn), .iStart(start1),
        .oA(a1), .oB(b1),
        .iAND(a1 & b1), .iOR(a1 | b1), .iNOT(f_not0 ? 1'b0 : ~a1),
        .iNAND(~(a1 & b1)), .iNAND2(~(a1 & b1)),
        .oBusy(busy1), .oDone(done1), .oPass(pass1),
        .oFailMask(mask1), .oFailVec(fv1), .oErrCnt(err1)
    );

    gates_bist #(.SETTLE_CYCLES(2), .LOOPS(2), .CNT_W(8)) u_dut2 (
        .iClk(clk), .iRstn(rstn), .iStart(start2),
        .oA(a2), .oB(b2),
        .iAND(a2 & b2), .iOR(a2 | b2), .iNOT(~a2),
        .iNAND(~(a2 & b2)), .iNAND2(f_nand2_1 ? 1'b1 : ~(a2 & b2)),
        .oBusy(busy2), .oDone(done2), .oPass(pass2),
        .oFailMask(mask2), .oFailVec(fv2), .oErrCnt(err2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on one instance and count edges until done (bounded)
    task automatic run_count(input bit sel2, output int n);
        if (sel2) start2 = 1'b1;
        else      start1 = 1'b1;
        tick();
        start1 = 1'b0;
        start2 = 1'b0;
        n = 0;
        while (n < 200 && !(sel2 ? done2 : done1)) begin
            tick();
            n++;
        end
    endtask

    initial begin
        rstn = 1'b0; start1 = 1'b0; start2 = 1'b0;
        f_not0 = 1'b0; f_nand2_1 = 1'b0;
        tick();
        tick();
        chk("rst_ctl1", {busy1, done1, pass1, a1, b1}, 5'b00000);
        chk("rst_res1", {mask1, fv1, err1}, 15'h0);
        chk("rst_ctl2", {busy2, done2, pass2, a2, b2}, 5'b00000);
        rstn = 1'b1;
        tick();
        chk("idle_hold", {busy1, done1}, 2'b00);

        // Good run: vector sequence and completion at edge 12
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("seq_e0", {busy1, done1, a1, b1}, 4'b1000);
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k < 12) chk($sformatf("seq_e%0d", k), {busy1, done1, a1, b1}, {2'b10, 2'(k / 3)});
        end
        chk("good_done", {busy1, done1, pass1, a1, b1}, 5'b01100);
        chk("good_res", {mask1, fv1, err1}, 15'h0);
        tick();
        tick();
        chk("good_sticky", {done1, pass1}, 2'b11);

        // NOT stuck at 0: restart from DONE clears results at the start edge
        f_not0 = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("restart_clr", {busy1, done1, pass1, mask1, fv1, err1}, 18'b100_00000_00_00000000);
        edges = 0;
        while (edges < 200 && !done1) begin
            tick();
            edges++;
        end
`ifdef GATES_BIST_STOP_ON_FAIL_EN
        chk("not0_lat", edges, 3);
        chk("not0_err", err1, 8'd1);
`else
        chk("not0_lat", edges, 12);
        chk("not0_err", err1, 8'd2);
`endif
        chk("not0_mask", mask1, 5'b00100);
        chk("not0_fvec", fv1, 2'b00);
        chk("not0_pass", {busy1, pass1}, 2'b00);

        // Good DUT again; starts at edges 4 and 7 are ignored
        f_not0 = 1'b0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("restart_err_clr", {err1, mask1}, 13'h0);
        edges = 0;
        while (edges < 200 && !done1) begin
            start1 = (edges == 3 || edges == 6);
            tick();
            edges++;
        end
        start1 = 1'b0;
        chk("ign_lat", edges, 12);
        chk("ign_pass", {pass1, err1}, 9'b1_00000000);

        // Reset at edge 5 mid-run abandons everything
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        chk("pre_rst_busy", {busy1, a1, b1}, 3'b101);
        rstn = 1'b0;
        tick();
        chk("midrst_ctl", {busy1, done1, pass1, a1, b1}, 5'b00000);
        chk("midrst_res", {mask1, fv1, err1}, 15'h0);
        rstn = 1'b1;
        tick();
        chk("midrst_idle", {busy1, done1}, 2'b00);
        run_count(1'b0, edges);
        chk("fresh_lat", edges, 12);
        chk("fresh_pass", {pass1, mask1, err1}, 14'b1_00000_00000000);

        // Two loops with NAND2 stuck at 1: only vector 11 fails
        f_nand2_1 = 1'b1;
        run_count(1'b1, edges);
`ifdef GATES_BIST_STOP_ON_FAIL_EN
        chk("loop2_lat", edges, 12);
        chk("loop2_err", err2, 8'd1);
`else
        chk("loop2_lat", edges, 24);
        chk("loop2_err", err2, 8'd2);
`endif
        chk("loop2_mask", mask2, 5'b10000);
        chk("loop2_fvec", fv2, 2'b11);
        chk("loop2_pass", {busy2, pass2, a2, b2}, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gates_bist.md
Name: gates_bist

Overview:
- Synthesizable built-in self-test engine for the two-input `gates` block.
- Drives the full 2-bit truth table (00, 01, 10, 11) onto the DUT inputs `iA`/`iB`, waits a programmable settle time, then samples the five DUT outputs and checks them against the expected logic.
- Reports pass/fail, an accumulated failing-output mask, the first failing vector and an error count.
- Sits beside `gates` in the example top; it is the hardware counterpart of the bench stimulus/checker.

Parameters:
- SETTLE_CYCLES, 2, cycles between applying a vector and sampling responses; legal range ≥1.
- LOOPS, 1, number of complete 4-vector passes per run; legal range ≥1.
- CNT_W, 8, width of the error counter.

Ports:
- iClk  input  1  clock, rising edge.
- iRstn  input  1  synchronous active-low reset.
- iStart  input  1  start pulse; sampled only in IDLE or DONE.
- oA  output  1  stimulus to DUT `iA`.
- oB  output  1  stimulus to DUT `iB`.
- iAND  input  1  DUT `oAND` response.
- iOR  input  1  DUT `oOR` response.
- iNOT  input  1  DUT `oNOT` response.
- iNAND  input  1  DUT `oNAND` response.
- iNAND2  input  1  DUT `oNAND2` response.
- oBusy  output  1  run in progress.
- oDone  output  1  run complete; sticky until the next start or reset.
- oPass  output  1  high only when oDone=1 and no mismatch was found.
- oFailMask  output  5  OR-accumulated per-output mismatch flags; bit order [0]=AND, [1]=OR, [2]=NOT, [3]=NAND, [4]=NAND2.
- oFailVec  output  2  {a,b} of the first mismatching vector; 0 if none.
- oErrCnt  output  CNT_W  number of mismatching vectors; saturates at all-ones.

Behaviour:
- Reset (iRstn=0 at a rising edge) forces all outputs to 0 and the state to IDLE. This applies from any state, including mid-run: the run is abandoned and no results are retained.
- States: IDLE, SETTLE, CHECK, DONE.
- Run start (IDLE or DONE, iStart=1 at an edge):
  - Clears oFailMask, oFailVec, oErrCnt and oDone.
  - Sets oBusy=1, vector index=0, loop=0, {oA,oB}=00, settle counter=0.
  - Moves to SETTLE.
- SETTLE:
  - Counter increments each edge.
  - At the edge where counter==SETTLE_CYCLES-1, moves to CHECK.
  - oA/oB are held stable.
- CHECK: sampled at one edge against the current {a,b}:
  - Expected values: AND=a&b, OR=a|b, NOT=~a, NAND=~(a&b), NAND2=~(a&b).
  - Each mismatching bit is ORed into oFailMask.
  - If any bit mismatches: oErrCnt increments (saturating), and oFailVec is loaded only if this is the first mismatch of the run.
  - In simulation, an X/Z response counts as a mismatch.
- After CHECK:
  - If the vector was 11 and loop==LOOPS-1, go to DONE.
  - Otherwise the vector advances (11 wraps to 00 and loop increments), oA/oB update at that same edge, the counter clears, and the state returns to SETTLE.
- DONE: oBusy=0, oDone=1, oPass=(oErrCnt==0). oA/oB return to 00. Results are held indefinitely.
- Latency: each vector takes SETTLE_CYCLES+1 cycles. oDone rises exactly 4*LOOPS*(SETTLE_CYCLES+1) edges after the start edge.
- iStart is ignored while oBusy=1.
- iStart=1 in DONE restarts the run at that edge (results are cleared at the same edge).
- oPass=0 whenever oDone=0.

Optional Feature:
- Macro GATES_BIST_STOP_ON_FAIL_EN.
- When defined: the first CHECK with any mismatch ends the run. At that edge the block records the mismatch (oErrCnt=1, oFailVec, oFailMask for that vector only) and enters DONE.
- When undefined: all vectors and loops always execute, and results accumulate as described above.

Test Plan:
- Good DUT, SETTLE_CYCLES=2, LOOPS=1, iStart pulse at edge 0 -> oBusy=1 from edge 0; {oA,oB} sequence 00, 01, 10, 11 with each held 3 cycles; oDone=1 after edge 12; oPass=1, oFailMask=00000, oErrCnt=0.
- iNOT forced to 0, macro undefined -> vectors 00 and 01 fail; oErrCnt=2, oFailMask=00100, oFailVec=00, oPass=0, oDone still after 12 cycles.
- LOOPS=2 with iNAND2 forced to 1 -> only vector 11 fails in each pass; oErrCnt=2, oFailMask=10000, oFailVec=11; oDone after 24 cycles.
- iStart pulsed at edges 4 and 7 during a run -> ignored; completion still at edge 12. iStart in DONE -> results clear and a new run starts.
- iRstn=0 at edge 5 mid-run -> next state IDLE; all outputs 0. A fresh start afterwards completes normally with oPass=1.
- With GATES_BIST_STOP_ON_FAIL_EN defined and iNOT forced to 0, SETTLE_CYCLES=2 -> oDone after edge 3; oErrCnt=1, oFailVec=00, oFailMask=00100.
